// File: rtl/wb_mem_sequencer.sv
// rtl/wb_mem_sequencer.sv - writeback-stage load/store sequencer owning the register-file write port (optional MEM_TIMEOUT_EN bus timeout)
module wb_mem_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        instr_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        load_byte,
    input  logic        read_pc_4,
    input  logic [4:0]  rd,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] alu_value,
    input  logic [31:0] pc_4_value,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_sel_q, bus_sel_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [4:0]  rd_q, rd_d;
    logic [1:0]  off_q, off_d;
    logic        byte_q, byte_d;

    logic        accept;
    logic        mem_op;
    logic        expire;
    logic [31:0] load_result;

    assign accept = ((state_q == IDLE) || (state_q == WB)) && instr_valid;
    assign mem_op = is_load | is_store;
    assign stall  = (state_q == REQ) | (accept & mem_op);

    // Byte loads return the lane selected by the captured low address bits, zero-extended
    assign load_result = byte_q ? {24'b0, bus_rdata[{off_q, 3'b000} +: 8]} : bus_rdata;

    assign bus_req  = bus_req_q;
    assign bus_we   = bus_we_q;
    assign bus_addr = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_sel  = bus_sel_q;
    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q, mem_err_d;

    // Expiry is the TIMEOUT_CYCLES-th REQ cycle without ack; an ack in that cycle completes normally
    assign expire  = (state_q == REQ) && !bus_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign mem_err = mem_err_q;

    // Wait counter: cleared when a transaction is launched, counts unacknowledged REQ cycles
    always_comb begin
        cnt_d     = cnt_q;
        mem_err_d = expire;
        if (accept && mem_op) begin
            cnt_d = '0;
        end else if ((state_q == REQ) && !bus_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter and error pulse registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end
`else
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

    // State and registered outputs; reset drops any outstanding transaction
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'b0;
            bus_wdata_q <= 32'b0;
            bus_sel_q   <= 4'b0;
            rf_we_q     <= 1'b0;
            rf_rd_q     <= 5'b0;
            rf_wdata_q  <= 32'b0;
            rd_q        <= 5'b0;
            off_q       <= 2'b0;
            byte_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            rf_we_q     <= rf_we_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            rd_q        <= rd_d;
            off_q       <= off_d;
            byte_q      <= byte_d;
        end
    end

    // Next state: launch on memory accept, leave REQ on ack (load goes through WB) or expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WB: begin
                state_d = (accept && mem_op) ? REQ : IDLE;
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = bus_we_q ? IDLE : WB;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: bus setup on memory accept, single rf write per retired instruction
    always_comb begin
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        rf_we_d     = 1'b0;
        rf_rd_d     = rf_rd_q;
        rf_wdata_d  = rf_wdata_q;
        rd_d        = rd_q;
        off_d       = off_q;
        byte_d      = byte_q;
        case (state_q)
            IDLE, WB: begin
                if (accept && mem_op) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_store & ~is_load;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_sel_d   = load_byte ? (4'b0001 << addr[1:0]) : 4'b1111;
                    bus_wdata_d = load_byte ? {4{store_data[7:0]}} : store_data;
                    rd_d        = rd;
                    off_d       = addr[1:0];
                    byte_d      = load_byte;
                end else if (accept) begin
                    rf_we_d    = (rd != 5'd0);
                    rf_rd_d    = rd;
                    rf_wdata_d = read_pc_4 ? pc_4_value : alu_value;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rf_we_d    = (rd_q != 5'd0);
                        rf_rd_d    = rd_q;
                        rf_wdata_d = load_result;
                    end
                end else if (expire) begin
                    bus_req_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
